// File: rtl/sram_pack_ctrl_pkg.sv
// Shared constants for the 4-word-write / 1-word-read line SRAM controller.
package sram_pack_ctrl_pkg;

  localparam int BEAT_WORDS = 4;
  localparam int WR_PTR_INC = BEAT_WORDS;
  localparam int RD_PTR_INC = 1;

  // Beats land on 4-word boundaries, so DEPTH must hold whole beats (at least two).
  function automatic bit depth_ok(input int depth);
    return ((depth % BEAT_WORDS) == 0) && (depth >= 2 * BEAT_WORDS);
  endfunction

endpackage

// File: rtl/sram_pack_ctrl.sv
// Width-converting FIFO control around a single-port line SRAM: 4-word beats in, 1 word/cycle out.
// Read data appears 1 cycle after issue; input stalls when fewer than 4 words free, output holds while stalled.
module sram_pack_ctrl
  import sram_pack_ctrl_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 128,
  parameter int ADDRB = $clog2(DEPTH),
  parameter int CNTB  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data_0,
  input  logic [WIDTH-1:0] in_data_1,
  input  logic [WIDTH-1:0] in_data_2,
  input  logic [WIDTH-1:0] in_data_3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTB-1:0]  level,
  output logic             sram_ena,
  output logic             sram_wea,
  output logic             sram_rea,
  output logic [ADDRB-1:0] sram_addr_i,
  output logic [ADDRB-1:0] sram_addr_o,
  output logic [WIDTH-1:0] sram_dina_0,
  output logic [WIDTH-1:0] sram_dina_1,
  output logic [WIDTH-1:0] sram_dina_2,
  output logic [WIDTH-1:0] sram_dina_3,
  input  logic [WIDTH-1:0] sram_douta
);

  if (!depth_ok(DEPTH)) begin : g_depth_chk
    $error("sram_pack_ctrl: DEPTH must be a multiple of 4 and at least 8");
  end

  localparam logic [CNTB-1:0]  WR_LIMIT = CNTB'(DEPTH - BEAT_WORDS);
  localparam logic [CNTB-1:0]  BEAT_CNT = CNTB'(BEAT_WORDS);
  localparam logic [ADDRB-1:0] WR_LAST  = ADDRB'(DEPTH - WR_PTR_INC);
  localparam logic [ADDRB-1:0] RD_LAST  = ADDRB'(DEPTH - RD_PTR_INC);

  logic [ADDRB-1:0] wr_ptr;
  logic [ADDRB-1:0] rd_ptr;
  logic [CNTB-1:0]  count;
  logic             out_valid_q;
  logic             wr_fire;
  logic             rd_issue;

  // Space check uses the registered count only; a read in the same cycle is not credited.
  assign in_ready = rst_n & ~flush & (count <= WR_LIMIT);
  assign wr_fire  = in_valid & in_ready;
  assign rd_issue = rst_n & ~flush & (count != '0) & (~out_valid_q | out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= (wr_ptr == WR_LAST) ? '0 : wr_ptr + ADDRB'(WR_PTR_INC);
      end
      if (rd_issue) begin
        rd_ptr <= (rd_ptr == RD_LAST) ? '0 : rd_ptr + ADDRB'(RD_PTR_INC);
      end
      count <= count + (wr_fire ? BEAT_CNT : '0) - CNTB'(rd_issue);
      if (rd_issue) begin
        out_valid_q <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = sram_douta;
  assign level       = count;
  assign sram_ena    = 1'b1;
  assign sram_wea    = wr_fire;
  assign sram_rea    = rd_issue;
  assign sram_addr_i = wr_ptr;
  assign sram_addr_o = rd_ptr;
  assign sram_dina_0 = in_data_0;
  assign sram_dina_1 = in_data_1;
  assign sram_dina_2 = in_data_2;
  assign sram_dina_3 = in_data_3;

endmodule

// File: tb/tb_sram_pack_ctrl.sv
// Bench for sram_pack_ctrl with a queue-based reference model and an SRAM behavioural model.
module tb_sram_pack_ctrl;

  localparam int W  = 10;
  localparam int D  = 16;
  localparam int AB = 4;
  localparam int CB = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data_0 = '0;
  logic [W-1:0]  in_data_1 = '0;
  logic [W-1:0]  in_data_2 = '0;
  logic [W-1:0]  in_data_3 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CB-1:0] level;
  logic          sram_ena;
  logic          sram_wea;
  logic          sram_rea;
  logic [AB-1:0] sram_addr_i;
  logic [AB-1:0] sram_addr_o;
  logic [W-1:0]  sram_dina_0;
  logic [W-1:0]  sram_dina_1;
  logic [W-1:0]  sram_dina_2;
  logic [W-1:0]  sram_dina_3;
  logic [W-1:0]  sram_douta = '0;
  logic [W-1:0]  mem [D];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sram_pack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data_0(in_data_0), .in_data_1(in_data_1), .in_data_2(in_data_2), .in_data_3(in_data_3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level),
    .sram_ena(sram_ena), .sram_wea(sram_wea), .sram_rea(sram_rea),
    .sram_addr_i(sram_addr_i), .sram_addr_o(sram_addr_o),
    .sram_dina_0(sram_dina_0), .sram_dina_1(sram_dina_1),
    .sram_dina_2(sram_dina_2), .sram_dina_3(sram_dina_3),
    .sram_douta(sram_douta)
  );

  // Single-port SRAM: 4-word write at a base address, registered 1-word read.
  always @(posedge clk) begin
    if (sram_wea) begin
      mem[int'(sram_addr_i)]     <= sram_dina_0;
      mem[int'(sram_addr_i) + 1] <= sram_dina_1;
      mem[int'(sram_addr_i) + 2] <= sram_dina_2;
      mem[int'(sram_addr_i) + 3] <= sram_dina_3;
    end
    if (sram_rea) sram_douta <= mem[int'(sram_addr_o)];
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words waiting in the SRAM are a queue, the output stage holds one word.
  int data_q[$];
  int m_cur = 0;
  bit m_ov = 1'b0;
  int m_w = 0;
  int m_r = 0;
  bit started = 1'b0;
  int last_rd_addr = -1;
  bit saw_rd_wrap = 1'b0;

  always @(negedge clk) begin : compare
    bit e_irdy;
    bit e_rea;
    bit e_wea;
    e_irdy = rst_n && !flush && (data_q.size() <= D - 4);
    e_rea  = rst_n && !flush && (data_q.size() != 0) && (!m_ov || out_ready);
    e_wea  = e_irdy && in_valid;
    if (started) begin
      chk("in_ready", in_ready, e_irdy);
      chk("sram_wea", sram_wea, e_wea);
      chk("sram_rea", sram_rea, e_rea);
      chk("sram_ena", sram_ena, 1);
      chk("level", level, data_q.size());
      chk("out_valid", out_valid, m_ov);
      if (e_wea) chk("sram_addr_i", sram_addr_i, m_w);
      if (e_rea) chk("sram_addr_o", sram_addr_o, m_r);
      if (m_ov) chk("out_data", out_data, m_cur);
    end
    if (sram_rea) begin
      if (last_rd_addr == D - 1 && sram_addr_o == '0) saw_rd_wrap = 1'b1;
      last_rd_addr = int'(sram_addr_o);
    end
    if (!rst_n || flush) begin
      data_q.delete();
      m_ov = 1'b0;
      m_w = 0;
      m_r = 0;
      last_rd_addr = -1;
      if (!rst_n) started = 1'b1;
    end else begin
      if (e_rea) begin
        m_cur = data_q.pop_front();
        m_ov = 1'b1;
        m_r = (m_r + 1) % D;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
      if (e_wea) begin
        data_q.push_back(int'(in_data_0));
        data_q.push_back(int'(in_data_1));
        data_q.push_back(int'(in_data_2));
        data_q.push_back(int'(in_data_3));
        m_w = (m_w + 4) % D;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int a, input int b, input int c, input int d);
    in_valid = 1'b1;
    in_data_0 = W'(a);
    in_data_1 = W'(b);
    in_data_2 = W'(c);
    in_data_3 = W'(d);
  endtask

  // Offer one beat until accepted; optionally randomise out_ready each cycle.
  task automatic push(input int base, input bit rnd);
    bit done;
    done = 1'b0;
    set_beat(base, base + 1, base + 2, base + 3);
    for (int k = 0; k < 200 && !done; k++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      #2;
      done = in_ready;
      cyc();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL push_timeout: beat %0d not accepted, required acceptance", base);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse();
    cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    out_ready = 1'b1;
    while (k < 200 && (level != '0 || out_valid)) begin
      cyc();
      k++;
    end
    if (k >= 200) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: level=%0d out_valid=%0d, required 0/0", level, out_valid);
    end
  endtask

  // Empty controller with pointers at 0: beat a..a+3 written at 0, read back in order.
  task automatic single_beat(input int a);
    out_ready = 1'b1;
    set_beat(a, a + 1, a + 2, a + 3);
    #2;
    chk("sb_wea", sram_wea, 1);
    chk("sb_addr_i", sram_addr_i, 0);
    cyc();
    in_valid = 1'b0;
    #2;
    chk("sb_rea", sram_rea, 1);
    chk("sb_addr_o", sram_addr_o, 0);
    chk("sb_level", level, 4);
    for (int k = 0; k < 4; k++) begin
      cyc();
      #2;
      chk("sb_out_valid", out_valid, 1);
      chk("sb_out_data", out_data, a + k);
      chk("sb_level_dec", level, 3 - k);
      chk("sb_rea_k", sram_rea, (k < 3) ? 1 : 0);
      if (k < 3) chk("sb_addr_o_k", sram_addr_o, k + 1);
    end
    cyc();
    #2;
    chk("sb_out_valid_end", out_valid, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit got;
    in_valid = 1'b1;
    repeat (3) cyc();
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wea", sram_wea, 0);
    chk("rst_rea", sram_rea, 0);
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    cyc();
    rst_n = 1'b1;
    in_valid = 1'b0;

    cyc();
    single_beat(1);

    // Fill: park one word in the output stage, then fill the SRAM to DEPTH.
    cyc();
    out_ready = 1'b0;
    push(11, 1'b0);
    repeat (3) pulse();
    for (int b = 0; b < 4; b++) push(20 + 4 * b, 1'b0);
    #2;
    chk("fill_level", level, 16);
    chk("fill_in_ready", in_ready, 0);
    set_beat(40, 41, 42, 43);
    for (int k = 0; k < 3; k++) begin
      cyc();
      #2;
      chk("fill_hold_wea", sram_wea, 0);
    end
    cyc();
    out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      #2;
      if (sram_wea) begin
        got = 1'b1;
        chk("fill_resume_addr", sram_addr_i, 8);
      end
      cyc();
    end
    chk("fill_resume", got, 1);
    in_valid = 1'b0;
    drain();

    // Random backpressure.
    for (int b = 0; b < 20; b++) push(100 + 4 * b, 1'b1);
    drain();

    // Steady beat every 4 cycles: continuous output, bounded level.
    out_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      push(200 + 4 * b, 1'b0);
      for (int k = 0; k < 3; k++) begin
        #2;
        chk("steady_level_max", (level <= 4) ? 1 : 0, 1);
        if (b > 0) chk("steady_thru", out_valid, 1);
        cyc();
      end
    end
    drain();

    // Wrap with consumption running.
    for (int b = 0; b < 10; b++) push(300 + 4 * b, 1'b1);
    drain();
    chk("rd_wrap_seen", saw_rd_wrap, 1);

    // Flush with level 9 and a stalled word in the output stage.
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) push(400 + 4 * b, 1'b0);
    repeat (2) pulse();
    #2;
    chk("pre_flush_level", level, 9);
    chk("pre_flush_out_valid", out_valid, 1);
    cyc();
    flush = 1'b1;
    set_beat(500, 501, 502, 503);
    out_ready = 1'b1;
    #2;
    chk("flush_wea", sram_wea, 0);
    chk("flush_rea", sram_rea, 0);
    chk("flush_in_ready", in_ready, 0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    #2;
    chk("post_flush_level", level, 0);
    chk("post_flush_out_valid", out_valid, 0);
    cyc();
    single_beat(7);

    // Reset mid-stream.
    cyc();
    out_ready = 1'b0;
    for (int b = 0; b < 3; b++) push(600 + 4 * b, 1'b0);
    repeat (2) pulse();
    #2;
    chk("pre_rst_level", level, 9);
    cyc();
    rst_n = 1'b0;
    #2;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_rea", sram_rea, 0);
    cyc();
    rst_n = 1'b1;
    #2;
    chk("post_rst_level", level, 0);
    chk("post_rst_out_valid", out_valid, 0);
    cyc();
    single_beat(21);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_pack_ctrl.md
Name: sram_pack_ctrl

Overview:
- Flow controller for the 4-word-write / 1-word-read single-port line SRAM.
- Accepts packed 4-word input beats over valid/ready and writes each beat as four consecutive words.
- Streams words back out one per cycle over valid/ready.
- Tracks occupancy and wraps both pointers circularly, so the SRAM behaves as a width-converting FIFO between the pixel packer and the downstream window stage.

Parameters:
- WIDTH, 10, word width in bits.
- DEPTH, 128, SRAM words; must be a multiple of 4 and at least 8.
- ADDRB, $clog2(DEPTH), SRAM address width.
- CNTB, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of pointers, count and output stage.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data_0..in_data_3  in  WIDTH each  words 0..3 of the beat; word 0 is oldest.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_data  out  WIDTH  output word; wired from sram_douta.
- level  out  CNTB  words held in SRAM and not yet fetched.
- sram_ena  out  1  constant 1.
- sram_wea  out  1  write strobe.
- sram_rea  out  1  read strobe.
- sram_addr_i  out  ADDRB  write base address.
- sram_addr_o  out  ADDRB  read address.
- sram_dina_0..sram_dina_3  out  WIDTH each  combinational copies of in_data_0..3.
- sram_douta  in  WIDTH  registered SRAM read data.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wr_ptr, rd_ptr, count, out_valid all 0.
  - in_ready=0 during reset; strobes 0.
- Write side:
  - in_ready = (count <= DEPTH-4) & ~flush & rst_n. The check is registered-count only; reads in the same cycle are not credited.
  - wr_fire = in_valid & in_ready drives sram_wea=1 and sram_addr_i=wr_ptr.
  - On wr_fire, wr_ptr += 4 modulo DEPTH.
  - wr_ptr[1:0] is always 0, so base+3 never crosses DEPTH.
- Read side:
  - rd_issue = (count != 0) & (~out_valid | out_ready) & ~flush.
  - rd_issue drives sram_rea=1 and sram_addr_o=rd_ptr; rd_ptr += 1 modulo DEPTH.
- Output stage:
  - Read latency is exactly 1 cycle; out_valid(t+1) = rd_issue(t).
  - Otherwise out_valid clears on out_valid & out_ready.
  - While stalled (out_valid & ~out_ready), sram_rea=0, so SRAM douta holds.
  - Sustained throughput is 1 word/cycle.
- Occupancy: count_next = count + 4·wr_fire − rd_issue; level = count.
  - count never exceeds DEPTH and never underflows.
- Read-after-write: words written at edge t are counted from t+1, so their earliest read issue is cycle t+1 and earliest out_valid is t+2. There is no same-cycle bypass.
- Simultaneous wr_fire and rd_issue are both legal. Addresses never collide because count>0 implies rd_ptr is outside the beat being written.
- Full: count=DEPTH-3..DEPTH gives in_ready=0. Empty: count=0 gives no rd_issue; out_valid drops after the last word is taken.
- flush: same effect as reset on the next edge. Any in-flight read is discarded (out_valid=0). No write occurs in the flush cycle.
- Reset or flush mid-stream loses buffered data; this is the intended behaviour.
- No FSM beyond the 1-bit output-stage state; all control is counter and handshake logic.

Decomposition:
- Shared package: BEAT_WORDS=4 and the pointer-increment constants; DEPTH legality check as an elaboration-time assertion.
- No sub-module. Top-level wrapper fish_linebuf pairs sram_pack_ctrl with sp_sram; it is out of scope here.

Test Plan (WIDTH=10, DEPTH=16):
- Single beat {1,2,3,4}, out_ready=1:
  - wea at t0, addr_i=0.
  - rea at t1..t4 with addr_o 0..3.
  - out_data 1,2,3,4 at t2..t5.
  - level 4→0.
- Fill: 4 back-to-back beats with out_ready=0:
  - level reaches 16 and in_ready=0.
  - A 5th beat is held (no wea).
  - After 4 words are drained, in_ready returns and wr_ptr wraps 12→0.
- Backpressure: toggle out_ready randomly for 20 beats:
  - Output sequence equals input order exactly.
  - out_data stable while out_valid & ~out_ready.
  - No rea during a stall.
- Simultaneous: steady beats every 4 cycles with out_ready=1:
  - level oscillates within 0..4.
  - Throughput is 1 word/cycle.
- Wrap: push 40 words total with consumption running:
  - rd_ptr wraps 15→0.
  - Data is correct across the wrap.
- Flush/reset mid-stream with level=9 and out_valid=1:
  - Next cycle: level=0, out_valid=0, pointers 0.
  - A new beat {7,8,9,10} is read back correctly from address 0.
